// File: rtl/bcd_stopwatch.sv
// Multi-digit BCD up/down stopwatch with prescaler, clear/load and
// active-low seven-segment decode for every digit.
module bcd_stopwatch #(
    parameter int DIV    = 50_000_000,
    parameter int DIGITS = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  run,
    input  logic                  up,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  tick,
    output logic                  wrap
);
    localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0]       presc;
    logic                tick_edge;
    logic [4*DIGITS-1:0] step_val;
    logic [4*DIGITS-1:0] load_sat;
    logic [DIGITS:0]     cy;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0001100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign tick_edge = run && (presc == LAST);
    assign cy[0]     = 1'b1;

    // Ripple carry/borrow chain: a digit steps only when every lower digit rolled.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic [3:0] d, stepped;
        logic       roll;
        assign d       = count[4*g +: 4];
        assign roll    = up ? (d >= 4'd9) : (d == 4'd0);
        assign stepped = up ? (roll ? 4'd0 : d + 4'd1)
                            : (roll ? 4'd9 : d - 4'd1);
        assign cy[g+1]             = cy[g] & roll;
        assign step_val[4*g +: 4]  = cy[g] ? stepped : d;
        assign load_sat[4*g +: 4]  = (load_val[4*g +: 4] > 4'd9) ? 4'd9 : load_val[4*g +: 4];
        assign seg[7*g +: 7]       = seg7(d);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            presc <= '0;
            count <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            if (clear) begin
                presc <= '0;
                count <= '0;
            end else begin
                // Load does not disturb the prescaler; it keeps its own cadence.
                if (run)
                    presc <= tick_edge ? '0 : presc + PW'(1);
                if (load) begin
                    count <= load_sat;
                end else if (tick_edge) begin
                    count <= step_val;
                    tick  <= 1'b1;
                    wrap  <= cy[DIGITS];
                end
            end
        end
    end
endmodule

// File: tb/tb_bcd_stopwatch.sv
// Randomised and directed checks of bcd_stopwatch (DIV=4, DIGITS=2) against
// an integer-valued reference model.
module tb_bcd_stopwatch;
    localparam int DIV    = 4;
    localparam int DIGITS = 2;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        run = 1'b0, up = 1'b1, clear = 1'b0, load = 1'b0;
    logic [7:0]  load_val = '0;
    logic [7:0]  count;
    logic [13:0] seg;
    logic        tick, wrap;

    int asserts = 0;
    int fails   = 0;
    int mc = 0;          // model count as a plain integer 0..99
    int mp = 0;          // model prescaler phase
    bit mtick = 0, mwrap = 0;

    logic [6:0] SEGT [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100};

    bcd_stopwatch #(.DIV(DIV), .DIGITS(DIGITS)) dut (
        .Clock(Clock), .Reset(Reset), .run(run), .up(up), .clear(clear), .load(load),
        .load_val(load_val), .count(count), .seg(seg), .tick(tick), .wrap(wrap)
    );

    always #5 Clock = ~Clock;

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    function automatic int sat_val(input logic [7:0] lv);
        int t, o;
        t = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
        o = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
        return t * 10 + o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(to_bcd(mc)));
        chk({tag, ".seg"},   32'(seg),   32'({SEGT[mc / 10], SEGT[mc % 10]}));
        chk({tag, ".tick"},  32'(tick),  32'(mtick));
        chk({tag, ".wrap"},  32'(wrap),  32'(mwrap));
    endtask

    // Apply inputs for one edge, advance the model, then check after the edge.
    task automatic step(input logic r, input logic u, input logic c, input logic l,
                        input logic [7:0] lv, input string tag);
        bit te;
        run = r; up = u; clear = c; load = l; load_val = lv;
        @(posedge Clock);
        mtick = 0; mwrap = 0;
        if (c) begin
            mc = 0; mp = 0;
        end else begin
            te = r && (mp == DIV - 1);
            if (r) mp = te ? 0 : mp + 1;
            if (l) mc = sat_val(lv);
            else if (te) begin
                mtick = 1;
                if (u) begin mwrap = (mc == 99); mc = (mc + 1) % 100; end
                else   begin mwrap = (mc == 0);  mc = (mc + 99) % 100; end
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic run_to_phase(input int ph, input logic u);
        int guard = 0;
        while (mp != ph && guard < 4 * DIV) begin
            step(1, u, 0, 0, 8'h00, "align");
            guard++;
        end
        chk("align_bound", 32'(mp), 32'(ph));
    endtask

    initial begin
        // Reset state
        #12;
        check_all("reset");
        chk("reset_seg_lit", 32'(seg), 32'(14'b0000001_0000001));
        #11 Reset = 1'b0;  // released between edges
        mc = 0; mp = 0;

        // Count up from reset: first tick DIV edges after release
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 8'h00, "up_pre");
        chk("first_tick_not_yet", 32'(tick), 32'(0));
        step(1, 1, 0, 0, 8'h00, "up_first");
        chk("first_tick", 32'(tick), 32'(1));
        chk("first_count", 32'(count), 32'(8'h01));
        chk("first_seg0", 32'(seg[6:0]), 32'(7'b1001111));
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 8'h00, "up_run");

        // Load 99 then roll over upward
        step(0, 1, 0, 1, 8'h99, "load99");
        for (int i = 0; i < DIV + 1; i++) step(1, 1, 0, 0, 8'h00, "up_wrap");

        // Load 10 then count down through borrow and underflow
        step(0, 0, 0, 1, 8'h10, "load10");
        for (int i = 0; i < 10 * DIV + 2; i++) step(1, 0, 0, 0, 8'h00, "down");
        step(0, 0, 0, 1, 8'h00, "load00");
        for (int i = 0; i < DIV + 1; i++) step(1, 0, 0, 0, 8'h00, "down_wrap");

        // Clear and load together on a tick edge
        run_to_phase(DIV - 1, 1);
        step(1, 1, 1, 1, 8'h42, "clr_load_tick");
        chk("clr_count", 32'(count), 32'(0));
        chk("clr_tick", 32'(tick), 32'(0));
        for (int i = 0; i < DIV; i++) step(1, 1, 0, 0, 8'h00, "after_clr");
        chk("clr_presc_restart", 32'(tick), 32'(1));

        // Run dropped mid-interval freezes everything
        run_to_phase(1, 1);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 8'h00, "frozen");
        for (int i = 0; i < DIV; i++) step(1, 1, 0, 0, 8'h00, "resume");

        // Saturating load then an asynchronous reset pulse between edges
        step(0, 1, 0, 1, 8'hA5, "loadA5");
        chk("loadA5_count", 32'(count), 32'(8'h95));
        step(1, 1, 0, 0, 8'h00, "pre_rst");
        #2 Reset = 1'b1;
        #1;
        mc = 0; mp = 0; mtick = 0; mwrap = 0;
        check_all("async_rst");
        @(posedge Clock); #1;
        check_all("rst_hold");
        #2 Reset = 1'b0;
        for (int i = 0; i < DIV - 1; i++) step(1, 1, 0, 0, 8'h00, "post_rst");
        step(1, 1, 0, 0, 8'h00, "post_rst_tick");

        // Random mix of all controls
        for (int i = 0; i < 400; i++)
            step(($urandom % 8) != 0, 1'($urandom), ($urandom % 40) == 0,
                 ($urandom % 30) == 0, 8'($urandom), "rand");

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule

// File: doc/bcd_stopwatch.md
BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

Interface
REQ-001 SHALL have parameter DIV, default 50_000_000, clock cycles per count tick (legal range 2 to 2^26).
REQ-002 SHALL have parameter DIGITS, default 4, number of BCD digits (legal range 1 to 8).
REQ-003 SHALL have port Clock  in  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port run  in  1  1 = prescaler and counter advance; 0 = hold.
REQ-006 SHALL have port up  in  1  1 = count up; 0 = count down; sampled on each tick.
REQ-007 SHALL have port clear  in  1  synchronous clear of count and prescaler.
REQ-008 SHALL have port load  in  1  synchronous load of count from load_val.
REQ-009 SHALL have port load_val  in  4*DIGITS  BCD load value; digit i is bits [4i+3:4i].
REQ-010 SHALL have port count  out  4*DIGITS  registered BCD count; digit 0 is least significant.
REQ-011 SHALL have port seg  out  7*DIGITS  active-low seven-segment drive for each digit; digit i is bits [7i+6:7i].
REQ-012 SHALL have port tick  out  1  one-cycle pulse, high in the cycle that count shows a tick update.
REQ-013 SHALL have port wrap  out  1  one-cycle pulse, high with tick when the count rolled over.

Function
REQ-014 SHALL hold a prescaler of ceil(log2(DIV)) bits that increments on each edge with run=1 and clear=0, and holds when run=0.
REQ-015 SHALL set the prescaler to 0 and perform one count step on an edge where the prescaler equals DIV-1 and run=1; that edge is a tick edge.
REQ-016 SHALL assert tick=1 (registered) for exactly the one cycle following each tick edge, and 0 otherwise.
REQ-017 SHALL apply priority clear > load > tick step when several occur on one edge.
REQ-018 SHALL, on clear, set count=0 and prescaler=0, and force tick=0 and wrap=0 for the next cycle.
REQ-019 SHALL, on load, set count=load_val, replacing any nibble >9 with 9; the prescaler keeps its value; tick=0 and wrap=0 for the next cycle.
REQ-020 SHALL, on an up step, increment count as a BCD number: a digit at 9 goes to 0 and carries into the next digit.
REQ-021 SHALL, on an up step from all digits 9, set count=0 and assert wrap with tick.
REQ-022 SHALL, on a down step, decrement count as a BCD number: a digit at 0 goes to 9 and borrows from the next digit.
REQ-023 SHALL, on a down step from count=0, set count to all 9s and assert wrap with tick.
REQ-024 SHALL decode seg combinationally from count, one bit per segment, field bit 6 = segment a through bit 0 = segment g, 0 = lit.
REQ-025 SHALL use these segment codes for digits 0-9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0001100.
REQ-026 SHALL drive 1111111 (blank) for any digit value >9.
REQ-027 SHALL leave count unchanged while run=0, apart from clear and load, which act regardless of run.
REQ-028 SHALL make the first tick after reset, with run held at 1, occur DIV edges after Reset is released.

Reset
REQ-029 SHALL, while Reset=1, asynchronously force count=0, prescaler=0, tick=0 and wrap=0, so seg shows 0000001 for every digit.
REQ-030 SHALL, on reset asserted mid-count, discard any partial prescaler value with no tick or wrap pulse emitted.

Verification
REQ-031 SHALL pass this case: DIV=4, DIGITS=2, run=1, up=1 from reset -> tick every 4 cycles, count 00, 01, 02 ...; seg digit 0 goes 0000001, 1001111.
REQ-032 SHALL pass this case: DIV=4, DIGITS=2, load 99 then run up -> next tick gives count=00 with wrap=1 for that cycle only.
REQ-033 SHALL pass this case: DIV=4, DIGITS=2, count=10, up=0 -> next tick gives 09 (borrow); from 00, next tick gives 99 with wrap=1.
REQ-034 SHALL pass this case: clear and load on the same edge as a tick edge -> count=0, tick=0, wrap=0, prescaler=0.
REQ-035 SHALL pass this case: run dropped for 10 cycles mid-interval -> count and prescaler frozen; the tick resumes after the remaining cycles of that interval.
REQ-036 SHALL pass this case: load_val=0xA5 -> count=95; Reset pulse asserted between clock edges -> count=00 immediately, with no tick afterwards.
